// File: rtl/jt12_wrsched_if.sv
// Write-request / register-file-write bundle between the bus interface and jt12_wrsched.
// master = CPU/bus side, slave = the scheduler.
interface jt12_wrsched_if #(
  parameter int DW = 8
) ();
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_ch;
  logic [1:0]    in_op;
  logic [DW-1:0] in_data;
  logic          wr_en;
  logic [4:0]    wr_slot;
  logic [DW-1:0] wr_data;
  logic          drop;
  logic          busy;

  modport master (
    output in_valid, in_ch, in_op, in_data,
    input  in_ready, wr_en, wr_slot, wr_data, drop, busy
  );

  modport slave (
    input  in_valid, in_ch, in_op, in_data,
    output in_ready, wr_en, wr_slot, wr_data, drop, busy
  );
endinterface

// File: rtl/jt12_wrsched.sv
// 24-slot operator sequencer (S1,S3,S2,S4 x 6 channels) with an in-order write FIFO that releases
// each write when its slot passes. Define JT12_WRSCHED_BYPASS_EN to let empty-FIFO hits skip the FIFO.
module jt12_wrsched #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cen,
  output logic             o_s1_enters,
  output logic             o_s2_enters,
  output logic             o_s3_enters,
  output logic             o_s4_enters,
  output logic [2:0]       o_cur_ch,
  output logic [4:0]       o_cur_slot,
  output logic             o_zero,
  jt12_wrsched_if.slave    bus
);

  localparam logic [AW:0] LpFull = (AW+1)'(DEPTH);

  logic [4:0]    r_slot;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_wr_en;
  logic [4:0]    r_wr_slot;
  logic [DW-1:0] r_wr_data;
  logic          r_drop;

  logic [4:0]    r_mem_slot [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];

  logic [1:0]    w_grp;
  logic [4:0]    w_grp_base;
  logic [4:0]    w_tgt_base;
  logic [4:0]    w_tgt;
  logic          w_ready;
  logic          w_accept;
  logic          w_bad;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;

  // Slot -> group/channel decode
  always_comb begin
    w_grp      = 2'd0;
    w_grp_base = 5'd0;
    if (r_slot >= 5'd18) begin
      w_grp      = 2'd3;
      w_grp_base = 5'd18;
    end else if (r_slot >= 5'd12) begin
      w_grp      = 2'd2;
      w_grp_base = 5'd12;
    end else if (r_slot >= 5'd6) begin
      w_grp      = 2'd1;
      w_grp_base = 5'd6;
    end
  end

  assign o_cur_slot  = r_slot;
  assign o_cur_ch    = 3'(r_slot - w_grp_base);
  assign o_s1_enters = (w_grp == 2'd0);
  assign o_s3_enters = (w_grp == 2'd1);
  assign o_s2_enters = (w_grp == 2'd2);
  assign o_s4_enters = (w_grp == 2'd3);
  assign o_zero      = (r_slot == 5'd23);

  // Operator number -> slot group base (S1,S2,S3,S4 live in groups 0,2,1,3)
  always_comb begin
    w_tgt_base = 5'd0;
    case (bus.in_op)
      2'd0:    w_tgt_base = 5'd0;
      2'd1:    w_tgt_base = 5'd12;
      2'd2:    w_tgt_base = 5'd6;
      default: w_tgt_base = 5'd18;
    endcase
    w_tgt = w_tgt_base + {2'b00, bus.in_ch};
  end

  assign w_empty  = (r_count == '0);
  assign w_ready  = (r_count != LpFull);
  assign w_accept = bus.in_valid & w_ready;
  assign w_bad    = (bus.in_ch > 3'd5);

`ifdef JT12_WRSCHED_BYPASS_EN
  assign w_bypass = w_accept & ~w_bad & w_empty & i_cen & (w_tgt == r_slot);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept & ~w_bad & ~w_bypass;
  // Only the head is eligible, which keeps writes in program order
  assign w_pop  = ~w_empty & i_cen & (r_mem_slot[r_rptr] == r_slot);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_slot[r_wptr] <= w_tgt;
      r_mem_data[r_wptr] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot    <= 5'd0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_slot <= 5'd0;
      r_wr_data <= '0;
      r_drop    <= 1'b0;
    end else begin
      if (i_cen) begin
        r_slot <= (r_slot == 5'd23) ? 5'd0 : r_slot + 5'd1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wr_en <= w_pop | w_bypass;
      if (w_pop) begin
        r_wr_slot <= r_mem_slot[r_rptr];
        r_wr_data <= r_mem_data[r_rptr];
      end else if (w_bypass) begin
        r_wr_slot <= w_tgt;
        r_wr_data <= bus.in_data;
      end
      r_drop <= w_accept & w_bad;
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_slot  = r_wr_slot;
  assign bus.wr_data  = r_wr_data;
  assign bus.drop     = r_drop;
  assign bus.busy     = ~w_empty | r_wr_en;

endmodule
